// File: rtl/hazard_sequencer_if.sv
// Pipeline-to-hazard-unit signal bundle: register indices and hazard flags in, forwarding selects and
// stall/flush/long-op status out. The pipeline holds the master side and the hazard sequencer holds the slave side.
interface hazard_sequencer_if;
   logic [4:0] d_rs1;
   logic [4:0] d_rs2;
   logic [4:0] e_rs1;
   logic [4:0] e_rs2;
   logic [4:0] e_rd;
   logic       e_mem_read;
   logic       e_long_op;
   logic       e_pc_src;
   logic [4:0] m_rd;
   logic       m_reg_write;
   logic [4:0] w_rd;
   logic       w_reg_write;

   logic [1:0] fwd_a;
   logic [1:0] fwd_b;
   logic       stall_f;
   logic       stall_d;
   logic       stall_e;
   logic       flush_d;
   logic       flush_e;
   logic       flush_m;
   logic       long_busy;
   logic       long_done;

   modport master (
      output d_rs1, d_rs2, e_rs1, e_rs2, e_rd, e_mem_read, e_long_op, e_pc_src,
      output m_rd, m_reg_write, w_rd, w_reg_write,
      input  fwd_a, fwd_b, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
      input  long_busy, long_done
   );

   modport slave (
      input  d_rs1, d_rs2, e_rs1, e_rs2, e_rd, e_mem_read, e_long_op, e_pc_src,
      input  m_rd, m_reg_write, w_rd, w_reg_write,
      output fwd_a, fwd_b, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
      output long_busy, long_done
   );
endinterface

// File: rtl/hazard_sequencer.sv
// Hazard control for the 5-stage RV32 pipeline: forwarding, load-use bubbles, branch flushes and the mul/div hold FSM.
// Defining HAZARD_STATS_EN adds the saturating stall_cycles / flush_events counters.
module hazard_sequencer #(
   parameter int LONG_LAT = 4,
   parameter int CNT_W    = 4
) (
   input  logic               clk,
   input  logic               reset,
   hazard_sequencer_if.slave  hz
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]        stall_cycles,
   output logic [31:0]        flush_events
`endif
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LONG_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;

   logic load_use;
   logic stall_f;
   logic stall_d;
   logic stall_e;
   logic flush_d;
   logic flush_e;
   logic flush_m;
   logic long_busy;
   logic long_done;

   // Memory result is newer than Writeback, so it wins; x0 is hardwired zero and never forwards.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic       m_we,
                                          input logic [4:0] m_rd,
                                          input logic       w_we,
                                          input logic [4:0] w_rd);
      logic [1:0] sel;
      sel = 2'b00;
      if (m_we && (m_rd != 5'd0) && (m_rd == rs)) begin
         sel = 2'b10;
      end else if (w_we && (w_rd != 5'd0) && (w_rd == rs)) begin
         sel = 2'b01;
      end
      return sel;
   endfunction

   always_comb begin
      hz.fwd_a = fwd_sel(hz.e_rs1, hz.m_reg_write, hz.m_rd, hz.w_reg_write, hz.w_rd);
      hz.fwd_b = fwd_sel(hz.e_rs2, hz.m_reg_write, hz.m_rd, hz.w_reg_write, hz.w_rd);
   end

   // rs2 is compared even for instructions that ignore it; a spurious bubble is cheaper than decoding usage.
   always_comb begin
      load_use = hz.e_mem_read && (hz.e_rd != 5'd0) &&
                 ((hz.e_rd == hz.d_rs1) || (hz.e_rd == hz.d_rs2));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // The long op only starts counting once it sits in Execute; on its final BUSY cycle Execute is released
   // while Fetch and Decode stay frozen for one more edge.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      stall_f    = 1'b0;
      stall_d    = 1'b0;
      stall_e    = 1'b0;
      flush_d    = 1'b0;
      flush_e    = 1'b0;
      flush_m    = 1'b0;
      long_busy  = 1'b0;
      long_done  = 1'b0;

      unique case (state)
         IDLE: begin
            if (hz.e_long_op && !hz.e_pc_src) begin
               state_next = BUSY;
               cnt_next   = LOAD_VAL;
            end
            if (!reset) begin
               if (hz.e_pc_src) begin
                  flush_d = 1'b1;
                  flush_e = 1'b1;
               end else if (load_use) begin
                  stall_f = 1'b1;
                  stall_d = 1'b1;
                  flush_e = 1'b1;
               end
            end
         end

         BUSY: begin
            cnt_next = cnt - CNT_ONE;
            if (cnt <= CNT_ONE) begin
               state_next = IDLE;
            end
            if (!reset) begin
               long_busy = 1'b1;
               stall_f   = 1'b1;
               stall_d   = 1'b1;
               if (cnt == CNT_ONE) begin
                  long_done = 1'b1;
               end else begin
                  stall_e = 1'b1;
                  flush_m = 1'b1;
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_comb begin
      hz.stall_f   = stall_f;
      hz.stall_d   = stall_d;
      hz.stall_e   = stall_e;
      hz.flush_d   = flush_d;
      hz.flush_e   = flush_e;
      hz.flush_m   = flush_m;
      hz.long_busy = long_busy;
      hz.long_done = long_done;
   end

`ifdef HAZARD_STATS_EN
   // Event counters stick at all-ones rather than wrapping so long runs never under-report.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         if (stall_f && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
         if (flush_d && (flush_events != 32'hFFFF_FFFF)) begin
            flush_events <= flush_events + 32'd1;
         end
      end
   end
`endif

endmodule
